// File: rtl/rx_buffer_pkg.sv
// Shared definitions for two-phase link blocks: flit width and the
// output-channel FSM state encoding.
`ifndef SIZE
`define SIZE 8
`endif

package rx_buffer_pkg;

  localparam int DATA_W = `SIZE;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } out_state_e;

endpackage

// File: rtl/rx_buffer_fifo_mem.sv
// Flit storage for rx_buffer: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
`ifndef SIZE
`define SIZE 8
`endif

module fifo_mem
  import rx_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/rx_buffer.sv
// Receive stage for a two-phase link: buffers incoming flits and re-issues
// them to the router over a second two-phase channel, one transfer at a time.
`ifndef SIZE
`define SIZE 8
`endif

module rx_buffer
  import rx_buffer_pkg::*;
#(
  parameter int    DEPTH = 4,
  parameter int    id    = -1,
  parameter string port  = "unknown"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   ack_in,
  output logic                   req_out,
  output logic [DATA_W-1:0]      data_out,
  input  logic                   ack_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  out_state_e        state_q, state_d;
  logic              ack_in_q, ack_in_d;
  logic              req_out_q, req_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] rd_data;
  logic              pending, full, push, pop;

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Full is judged on the occupancy before this cycle's pop, so a freed slot
  // only becomes usable on the following edge.
  always_comb begin
    pending = req_in ^ ack_in_q;
    full    = (count_q == FULL_CNT);
    push    = pending && !full;
    pop     = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_out == req_out_q) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    ack_in_d   = ack_in_q ^ push;
    req_out_d  = req_out_q ^ pop;
    data_out_d = pop ? rd_data : data_out_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_in_q   <= 1'b0;
      req_out_q  <= 1'b0;
      data_out_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ack_in_q   <= ack_in_d;
      req_out_q  <= req_out_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Overflow and underflow cannot happen in a correct design; flag them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full))
        else $error("rx_buffer %s (router %0d): push into full FIFO", port, id);
      assert (!(pop && (count_q == '0)))
        else $error("rx_buffer %s (router %0d): pop from empty FIFO", port, id);
    end
  end

  assign ack_in   = ack_in_q;
  assign req_out  = req_out_q;
  assign data_out = data_out_q;
  assign count    = count_q;

endmodule

// File: tb/tb_rx_buffer.sv
// Self-checking bench for rx_buffer: directed handshake scenarios plus
// randomized traffic checked against a queue-based link model.
`ifndef SIZE
`define SIZE 8
`endif

module tb_rx_buffer;

  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             req_in;
  logic [`SIZE-1:0] data_in;
  logic             ack_in;
  logic             req_out;
  logic [`SIZE-1:0] data_out;
  logic             ack_out;
  logic [2:0]       count;

  int checks;
  int errors;

  // Link model: FIFO contents in arrival order plus the expected handshake phases.
  logic [`SIZE-1:0] model_q [$];
  logic             m_ack_in;
  logic             m_req_out;
  logic [`SIZE-1:0] m_data_out;

  rx_buffer #(
    .DEPTH (DEPTH),
    .id    (3),
    .port  ("east")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .data_in  (data_in),
    .ack_in   (ack_in),
    .req_out  (req_out),
    .data_out (data_out),
    .ack_out  (ack_out),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic applyStimulus(input logic [`SIZE-1:0] d);
    data_in = d;
    req_in  = ~req_in;
  endtask

  task automatic modelReset();
    model_q.delete();
    m_ack_in   = 1'b0;
    m_req_out  = 1'b0;
    m_data_out = '0;
  endtask

  // One clock: predict from the link rules, advance, then compare every output.
  task automatic cycle(output logic popped);
    logic             pend;
    logic             free;
    logic             do_push;
    logic             do_pop;
    logic [`SIZE-1:0] din;
    int               occ;
    pend    = (req_in != m_ack_in);
    free    = (ack_out == m_req_out);
    occ     = model_q.size();
    din     = data_in;
    do_push = pend && (occ < DEPTH);
    do_pop  = free && (occ > 0);
    @(posedge clk);
    #1;
    if (do_pop) begin
      m_data_out = model_q.pop_front();
      m_req_out  = ~m_req_out;
    end
    if (do_push) begin
      model_q.push_back(din);
      m_ack_in = ~m_ack_in;
    end
    checkOutput("model_ack_in", 32'(ack_in), 32'(m_ack_in));
    checkOutput("model_req_out", 32'(req_out), 32'(m_req_out));
    checkOutput("model_data_out", 32'(data_out), 32'(m_data_out));
    checkOutput("model_count", 32'(count), 32'(model_q.size()));
    popped = do_pop;
  endtask

  task automatic pulseReset();
    reset   = 1'b1;
    req_in  = 1'b0;
    ack_out = 1'b0;
    data_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic p;
    int   sent;
    int   delivered;
    int   first_pop;
    int   last_pop;

    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    req_in  = 1'b0;
    ack_out = 1'b0;
    data_in = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_ack_in", 32'(ack_in), 32'd0);
    checkOutput("rst_req_out", 32'(req_out), 32'd0);
    checkOutput("rst_data_out", 32'(data_out), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);

    // Single flit pass-through latency.
    applyStimulus(8'hA5);
    cycle(p);
    checkOutput("a5_ack_in", 32'(ack_in), 32'd1);
    checkOutput("a5_req_early", 32'(req_out), 32'd0);
    cycle(p);
    checkOutput("a5_req_out", 32'(req_out), 32'd1);
    checkOutput("a5_data_out", 32'(data_out), 32'hA5);
    ack_out = m_req_out;
    cycle(p);

    // Fill with the router stalled.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(`SIZE'(i));
      cycle(p);
    end
    checkOutput("fill_count", 32'(count), 32'd3);
    checkOutput("fill_data_out", 32'(data_out), 32'h01);
    checkOutput("fill_ack_in", 32'(ack_in), 32'd1);
    applyStimulus(8'h05);
    cycle(p);
    checkOutput("fifth_ack_in", 32'(ack_in), 32'd0);
    checkOutput("fifth_count", 32'(count), 32'd4);
    applyStimulus(8'h06);
    cycle(p);
    checkOutput("full_hold_ack", 32'(ack_in), 32'd0);
    cycle(p);
    checkOutput("full_hold_ack2", 32'(ack_in), 32'd0);
    checkOutput("full_count", 32'(count), 32'd4);

    // Recovery from full: pop first, held input accepted one edge later.
    ack_out = m_req_out;
    cycle(p);
    checkOutput("recov_data_out", 32'(data_out), 32'h02);
    checkOutput("recov_count", 32'(count), 32'd3);
    checkOutput("recov_ack_same", 32'(ack_in), 32'd0);
    cycle(p);
    checkOutput("recov_ack_next", 32'(ack_in), 32'd1);
    checkOutput("recov_count_next", 32'(count), 32'd4);

    // Asynchronous reset with three buffered flits and a transfer in flight.
    ack_out = m_req_out;
    cycle(p);
    checkOutput("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("async_ack_in", 32'(ack_in), 32'd0);
    checkOutput("async_req_out", 32'(req_out), 32'd0);
    checkOutput("async_data_out", 32'(data_out), 32'd0);
    checkOutput("async_count", 32'(count), 32'd0);
    pulseReset();
    applyStimulus(8'h5A);
    cycle(p);
    checkOutput("post_rst_ack", 32'(ack_in), 32'd1);
    cycle(p);
    checkOutput("post_rst_req", 32'(req_out), 32'd1);
    checkOutput("post_rst_data", 32'(data_out), 32'h5A);
    ack_out = m_req_out;
    cycle(p);

    // Simultaneous push and pop at occupancy two.
    applyStimulus(8'h11);
    cycle(p);
    applyStimulus(8'h22);
    cycle(p);
    applyStimulus(8'h33);
    cycle(p);
    checkOutput("pp_count_before", 32'(count), 32'd2);
    applyStimulus(8'h44);
    ack_out = m_req_out;
    cycle(p);
    checkOutput("pp_count_after", 32'(count), 32'd2);
    checkOutput("pp_data_out", 32'(data_out), 32'h22);
    for (int i = 0; i < 6; i++) begin
      ack_out = m_req_out;
      cycle(p);
    end
    checkOutput("pp_drained", 32'(count), 32'd0);

    // Streaming with an always-ready router: expect one flit per cycle.
    pulseReset();
    sent      = 0;
    delivered = 0;
    first_pop = -1;
    last_pop  = -1;
    for (int c = 0; c < 40 && delivered < 16; c++) begin
      if (req_in == m_ack_in && sent < 16) begin
        applyStimulus(`SIZE'(sent));
        sent++;
      end
      cycle(p);
      if (p) begin
        checkOutput("stream_data", 32'(data_out), 32'(delivered));
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        delivered++;
      end
      ack_out = m_req_out;
    end
    checkOutput("stream_delivered", 32'(delivered), 32'd16);
    checkOutput("stream_gapless", 32'(last_pop - first_pop), 32'd15);

    // Randomized traffic: congested, then lightly loaded, then drain.
    for (int c = 0; c < 600; c++) begin
      int send_pct;
      int ack_pct;
      send_pct = (c < 300) ? 70 : 30;
      ack_pct  = (c < 300) ? 35 : 85;
      if (req_in == m_ack_in && $urandom_range(0, 99) < send_pct) begin
        applyStimulus(`SIZE'($urandom));
      end
      if (ack_out != m_req_out && $urandom_range(0, 99) < ack_pct) begin
        ack_out = m_req_out;
      end
      cycle(p);
    end
    for (int c = 0; c < 20; c++) begin
      ack_out = m_req_out;
      cycle(p);
    end
    checkOutput("final_count", 32'(count), 32'd0);
    checkOutput("final_idle", 32'(req_out ^ ack_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_buffer.md
# rx_buffer

Downstream receive stage for the router's two-phase (toggle) links. It consumes the req/ack/data channel driven by a link transceiver, buffers up to DEPTH flits in a FIFO, and re-issues them to the router input logic over a second two-phase channel. When the FIFO is full it withholds the input ack, so backpressure propagates upstream.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- id, -1: parent router id; debug and identification only.
- port, "unknown": port name string; debug only.
- Data width is the global `SIZE define, default 8.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_in  input  1  two-phase request from the upstream transceiver.
- data_in  input  `SIZE  flit; valid whenever req_in != ack_in.
- ack_in  output  1  two-phase ack to upstream; registered.
- req_out  output  1  two-phase request to the router; registered.
- data_out  output  `SIZE  flit presented to the router; registered, stable while req_out != ack_out.
- ack_out  input  1  two-phase ack from the router.
- count  output  log2(DEPTH)+1  current FIFO occupancy; excludes the flit held in data_out.

## Operation
- Input side:
  - A transfer is pending when req_in != ack_in.
  - If a transfer is pending and count < DEPTH: write data_in at the tail, advance the write pointer, toggle ack_in.
  - If count == DEPTH: hold ack_in unchanged. The upstream is required to keep data_in stable until the ack arrives.
- Output FSM, two states:
  - IDLE: if count > 0, load the head into data_out, pop the FIFO, toggle req_out, go to WAIT.
  - WAIT: when ack_out == req_out the transfer is complete.
    - If count > 0, launch the next flit in the same cycle (load, pop, toggle) and stay in WAIT.
    - Otherwise go to IDLE.
- Simultaneous push and pop in one cycle: both occur and count is unchanged.
- The full check uses count before that cycle's pop. There is no same-cycle bypass.
- Pointers wrap modulo DEPTH. count saturates at neither end in a correct design.
  - Push when full, or pop when empty, is impossible by construction.
  - Simulation asserts flag either event as an error.
- At most one transfer is ever outstanding on the output channel.

## Timing
- Reset values (async assert): ack_in=0, req_out=0, data_out=0, count=0, read/write pointers=0, FSM=IDLE. FIFO storage is not reset.
- Reset mid-operation discards all buffered and in-flight flits. Upstream and downstream share the same reset, so phases realign at 0.
- Input accept latency: req_in toggles before edge t (and pending with space) → ack_in toggles after edge t. That is one cycle, with data captured at edge t.
- Pass-through latency into an empty, idle block:
  - data written at edge t;
  - req_out toggles with data_out valid after edge t+1.
- Output throughput: one flit per cycle when ack_out returns within a cycle. The next launch happens on the edge where ack_out == req_out is first sampled.
- Full recovery: a pop at edge t makes count < DEPTH. A held pending input is accepted at edge t+1.
- All inputs are synchronous to clk. There is no internal synchronizer.

## Structure
- State encoding localparams (IDLE, WAIT) belong in a shared link-protocol include, next to the `SIZE define, for reuse by other two-phase link blocks.
- One sub-module, fifo_mem: DEPTH × `SIZE register file with one synchronous write port and one combinational read port, addressed by the pointers.
- rx_buffer owns the pointers, count, handshake registers and output FSM.

## Test plan
- After reset: ack_in=0, req_out=0, count=0. Toggle req_in with data_in=8'hA5 → ack_in=1 one cycle later, then req_out=1 with data_out=8'hA5 the following cycle.
- Hold ack_out, send 4 flits 01..04 with DEPTH=4 → ack_in toggles 4 times, count reaches 3 (01 held in data_out). Then:
  - Send a 5th flit 05 → accepted, count=4.
  - Send a 6th flit 06 → ack_in stays unchanged.
- From the full state, toggle ack_out once → 02 is launched and count drops to 3. The pending 06 is acked on the next cycle.
- Router acks immediately every cycle, upstream streams 16 flits 00..0F → output order matches 00..0F, with no gaps after the pipeline fills. Pointers wrap four times.
- Assert reset with count=3 and req_out outstanding → all outputs go to their reset values immediately. A new flit after reset is delivered correctly with phase 0→1.
- Simultaneous push and pop at count=2 → count stays at 2, and the order is preserved.
